// File: rtl/led_status_pkg.sv
// Shared definitions for the status-LED driver: channel mode codes and burst FSM states.
package led_status_pkg;

  localparam logic [2:0] LED_OFF   = 3'd0;
  localparam logic [2:0] LED_ON    = 3'd1;
  localparam logic [2:0] LED_SLOW  = 3'd2;
  localparam logic [2:0] LED_FAST  = 3'd3;
  localparam logic [2:0] LED_BURST = 3'd4;

  typedef enum logic [1:0] {
    ST_GAP = 2'd0,
    ST_ON  = 2'd1,
    ST_OFF = 2'd2
  } burst_state_e;

endpackage

// File: rtl/led_burst_fsm.sv
// Per-channel burst-code sequencer: dark gap, then n flashes of BURST_ON ticks on / BURST_ON ticks off.
module led_burst_fsm
  import led_status_pkg::*;
#(
  parameter int BURST_ON  = 64,
  parameter int BURST_GAP = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       enable,
  input  logic [3:0] burst_cnt,
  output logic       lit
);

  localparam int CNT_MAX = (BURST_GAP > BURST_ON) ? BURST_GAP : BURST_ON;
  localparam int TCNT_W  = $clog2(CNT_MAX + 1);
  localparam logic [TCNT_W-1:0] GAP_LAST = TCNT_W'(BURST_GAP - 1);
  localparam logic [TCNT_W-1:0] ON_LAST  = TCNT_W'(BURST_ON - 1);

  burst_state_e      state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic [3:0]        n_q, n_d;
  logic              lit_q, lit_d;

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    fcnt_d  = fcnt_q;
    n_d     = n_q;
    // Leaving or entering burst mode always restarts from a fresh gap.
    if (!enable) begin
      state_d = ST_GAP;
      tcnt_d  = '0;
      fcnt_d  = '0;
    end else if (tick) begin
      case (state_q)
        ST_GAP: begin
          if (tcnt_q == GAP_LAST) begin
            n_d     = burst_cnt;
            tcnt_d  = '0;
            fcnt_d  = '0;
            state_d = (burst_cnt != 4'd0) ? ST_ON : ST_GAP;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
        ST_ON: begin
          if (tcnt_q == ON_LAST) begin
            tcnt_d  = '0;
            fcnt_d  = fcnt_q + 4'd1;
            state_d = ST_OFF;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
        ST_OFF: begin
          if (tcnt_q == ON_LAST) begin
            tcnt_d  = '0;
            state_d = (fcnt_q == n_q) ? ST_GAP : ST_ON;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
        default: begin
          state_d = ST_GAP;
          tcnt_d  = '0;
          fcnt_d  = '0;
        end
      endcase
    end
    lit_d = (state_d == ST_ON);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_GAP;
      tcnt_q  <= '0;
      fcnt_q  <= '0;
      n_q     <= '0;
      lit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      fcnt_q  <= fcnt_d;
      n_q     <= n_d;
      lit_q   <= lit_d;
    end
  end

  assign lit = lit_q;

endmodule

// File: rtl/led_status_ctrl.sv
// Multi-channel status-LED driver with shared prescaler/phase counter and a host liveness echo.
module led_status_ctrl
  import led_status_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int TICK_DIV   = 8192,
  parameter int PH_W       = 12,
  parameter int SLOW_BIT   = 11,
  parameter int FAST_BIT   = 8,
  parameter int BURST_ON   = 64,
  parameter int BURST_GAP  = 512,
  parameter int ECHO_W     = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                i_fpga_clk,
  input  logic                i_rst_n,
  input  logic [3*N_CH-1:0]   i_mode,
  input  logic [4*N_CH-1:0]   i_burst_cnt,
  input  logic                i_lamp_test,
  input  logic [ECHO_W-1:0]   i_fpga_workin,
  output logic [ECHO_W-1:0]   o_fpga_workout,
  output logic                o_tick,
  output logic [N_CH-1:0]     o_led
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [N_CH-1:0]    LED_INV    = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_q, tick_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [N_CH-1:0]    led_q, led_d;
  logic [ECHO_W-1:0]  echo_q, echo_d;
  logic [N_CH-1:0]    burst_en;
  logic [N_CH-1:0]    burst_lit;
  logic [N_CH-1:0]    lit;

  always_comb begin
    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
    tick_d  = (presc_q == PRESC_LAST);
    phase_d = tick_q ? phase_q + PH_W'(1) : phase_q;
    echo_d  = i_fpga_workin + ECHO_W'(1);
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign burst_en[k] = (i_mode[3*k +: 3] == LED_BURST);

    led_burst_fsm #(
      .BURST_ON  (BURST_ON),
      .BURST_GAP (BURST_GAP)
    ) u_burst (
      .clk       (i_fpga_clk),
      .rst_n     (i_rst_n),
      .tick      (tick_q),
      .enable    (burst_en[k]),
      .burst_cnt (i_burst_cnt[4*k +: 4]),
      .lit       (burst_lit[k])
    );
  end

  // Reserved mode codes fall through to dark, same as OFF.
  always_comb begin
    lit = '0;
    for (int k = 0; k < N_CH; k++) begin
      case (i_mode[3*k +: 3])
        LED_ON:    lit[k] = 1'b1;
        LED_SLOW:  lit[k] = phase_q[SLOW_BIT];
        LED_FAST:  lit[k] = phase_q[FAST_BIT];
        LED_BURST: lit[k] = burst_lit[k];
        default:   lit[k] = 1'b0;
      endcase
    end
    led_d = ({N_CH{i_lamp_test}} | lit) ^ LED_INV;
  end

  always_ff @(posedge i_fpga_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      phase_q <= '0;
      led_q   <= LED_INV;
      echo_q  <= '0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
      led_q   <= led_d;
      echo_q  <= echo_d;
    end
  end

  assign o_tick         = tick_q;
  assign o_led          = led_q;
  assign o_fpga_workout = echo_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Randomised bench for led_status_ctrl, compared each cycle against a timeline-based reference model.
module tb_led_status_ctrl;

  localparam int N_CH       = 4;
  localparam int TICK_DIV   = 2;
  localparam int PH_W       = 4;
  localparam int SLOW_BIT   = 3;
  localparam int FAST_BIT   = 1;
  localparam int BURST_ON   = 2;
  localparam int BURST_GAP  = 4;
  localparam int ECHO_W     = 8;
  localparam int ACTIVE_LOW = 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [3*N_CH-1:0]   mode;
  logic [4*N_CH-1:0]   burst_cnt;
  logic                lamp;
  logic [ECHO_W-1:0]   workin;
  logic [ECHO_W-1:0]   workout;
  logic                tick;
  logic [N_CH-1:0]     led;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state: edges since reset and each channel's position in its burst timeline.
  int          cyc;
  int          bPos [N_CH];
  bit          bGap [N_CH];
  int          bN   [N_CH];
  logic [N_CH-1:0]   expLed;
  logic              expTick;
  logic [ECHO_W-1:0] expEcho;

  led_status_ctrl #(
    .N_CH       (N_CH),
    .TICK_DIV   (TICK_DIV),
    .PH_W       (PH_W),
    .SLOW_BIT   (SLOW_BIT),
    .FAST_BIT   (FAST_BIT),
    .BURST_ON   (BURST_ON),
    .BURST_GAP  (BURST_GAP),
    .ECHO_W     (ECHO_W),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) dut (
    .i_fpga_clk     (clk),
    .i_rst_n        (rst_n),
    .i_mode         (mode),
    .i_burst_cnt    (burst_cnt),
    .i_lamp_test    (lamp),
    .i_fpga_workin  (workin),
    .o_fpga_workout (workout),
    .o_tick         (tick),
    .o_led          (led)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    cyc = 0;
    for (int k = 0; k < N_CH; k++) begin
      bPos[k] = 0;
      bGap[k] = 1'b1;
      bN[k]   = 0;
    end
    expLed  = (ACTIVE_LOW != 0) ? '1 : '0;
    expTick = 1'b0;
    expEcho = '0;
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic modelStep();
    bit tickNow;
    int phase;
    int m;
    bit litK;
    tickNow = (cyc > 0) && (cyc % TICK_DIV == 0);
    phase   = (cyc > 0) ? ((cyc - 1) / TICK_DIV) % (1 << PH_W) : 0;
    for (int k = 0; k < N_CH; k++) begin
      m = int'(mode[3*k +: 3]);
      case (m)
        1:       litK = 1'b1;
        2:       litK = ((phase >> SLOW_BIT) & 1) != 0;
        3:       litK = ((phase >> FAST_BIT) & 1) != 0;
        4:       litK = !bGap[k] && ((bPos[k] / BURST_ON) % 2 == 0);
        default: litK = 1'b0;
      endcase
      expLed[k] = (lamp | litK) ^ (ACTIVE_LOW != 0);
      if (m != 4) begin
        bGap[k] = 1'b1;
        bPos[k] = 0;
      end else if (tickNow) begin
        bPos[k]++;
        if (bGap[k] && bPos[k] == BURST_GAP) begin
          bN[k]   = int'(burst_cnt[4*k +: 4]);
          bPos[k] = 0;
          bGap[k] = (bN[k] == 0);
        end else if (!bGap[k] && bPos[k] == 2 * bN[k] * BURST_ON) begin
          bGap[k] = 1'b1;
          bPos[k] = 0;
        end
      end
    end
    expEcho = workin + 8'd1;
    cyc++;
    expTick = (cyc % TICK_DIV == 0);
  endtask

  task automatic applyStimulus(input int iter);
    int ch;
    if ($urandom_range(63) == 0) begin
      ch = $urandom_range(N_CH - 1);
      mode[3*ch +: 3] = ($urandom_range(1) == 1) ? 3'd4 : 3'($urandom_range(7));
    end
    if ($urandom_range(31) == 0) begin
      ch = $urandom_range(N_CH - 1);
      burst_cnt[4*ch +: 4] = 4'($urandom_range(3));
    end
    if ($urandom_range(49) == 0) lamp = ~lamp;
    workin = 8'($urandom);
    if (iter % 97 == 5) workin = 8'hFF;
    if (iter % 97 == 6) workin = 8'h5A;
  endtask

  task automatic stepAndCheck();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput("led", led, expLed);
    checkOutput("tick", tick, expTick);
    checkOutput("echo", workout, expEcho);
  endtask

  task automatic runRandom(input int n);
    for (int i = 0; i < n; i++) begin
      stepAndCheck();
      applyStimulus(i);
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    mode      = '0;
    burst_cnt = '0;
    lamp      = 1'b0;
    workin    = '0;
    modelReset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_led", led, 4'hF);
    checkOutput("reset_echo", workout, 8'h00);
    checkOutput("reset_tick", tick, 1'b0);

    burst_cnt = 16'h3213;
    rst_n = 1'b1;
    runRandom(3000);

    mode[2:0] = 3'd1;
    lamp      = 1'b0;
    workin    = 8'h5A;
    for (int i = 0; i < 4; i++) stepAndCheck();
    checkOutput("ch0_on_lit", led[0], 1'b0);
    checkOutput("echo_5a", workout, 8'h5B);

    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_led", led, 4'hF);
    checkOutput("async_reset_echo", workout, 8'h00);
    checkOutput("async_reset_tick", tick, 1'b0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    runRandom(3000);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
